// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and defaults for the register write arbiter
//
// Purpose : holds the arbiter FSM state encoding and the default
//           requester count / data width used by reg_write_arbiter and rr_pick.
// Ports   : none (package).

package reg_arb_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 8;

   // Explicit encodings keep the state register readable in waveforms.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
//
// Purpose : picks the first asserted request searching upward from
//           (i_ptr + 1) mod N_REQ, wrapping around, so the last winner
//           gets lowest priority on the next pick.
// Ports   : i_req    - per-requester request vector
//           i_ptr    - index of the most recent winner
//           o_onehot - one-hot winner (all zero when nothing requested)
//           o_idx    - binary index of the winner
//           o_valid  - high when at least one request is asserted

import reg_arb_pkg::*;

module rr_pick #(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   logic [IDX_W-1:0] w_cand;

   // k runs 1..N_REQ so the previous winner (k == N_REQ) is checked last;
   // the first hit freezes the result through o_valid.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_cand   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
         if (!o_valid && i_req[w_cand]) begin
            o_valid          = 1'b1;
            o_idx            = w_cand;
            o_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for writes to one shared register
//
// Purpose : N_REQ requesters compete to write a shared WIDTH-bit register.
//           Each transaction runs IDLE -> GRANT -> COMMIT; the write lands
//           on the GRANT->COMMIT edge and is acknowledged during COMMIT.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous active-high reset
//           en    - allows new grants out of IDLE
//           req   - per-requester write request
//           wdata - packed write data, requester i at [i*WIDTH +: WIDTH]
//           gnt   - registered one-hot grant, high during GRANT
//           ack   - registered one-hot write-complete pulse, high during COMMIT
//           q     - shared register contents
//           busy  - high whenever the FSM is not IDLE

import reg_arb_pkg::*;

module reg_write_arbiter #(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       q,
   output logic                   busy
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_sel;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] r_ack;
   logic [WIDTH-1:0] r_q;

   logic [N_REQ-1:0] w_pick_onehot;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_valid;
   logic [WIDTH-1:0] w_wsel;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

   // Write-data mux on the latched selection, built with constant slices.
   always_comb begin
      w_wsel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_sel == IDX_W'(i)) begin
            w_wsel = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= IDX_W'(N_REQ - 1);
         r_sel   <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_q     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (en && w_pick_valid) begin
                  r_sel   <= w_pick_idx;
                  r_gnt   <= w_pick_onehot;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               r_gnt <= '0;
               // A withdrawn request abandons the slot without touching
               // q or ptr, so the same requester keeps its priority.
               if (req[r_sel]) begin
                  r_q     <= w_wsel;
                  r_ack   <= r_gnt;
                  r_state <= COMMIT;
               end else begin
                  r_state <= IDLE;
               end
            end
            COMMIT: begin
               r_ack   <= '0;
               r_ptr   <= r_sel;
               r_state <= IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_ack   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign gnt  = r_gnt;
   assign ack  = r_ack;
   assign q    = r_q;
   assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter

module tb_reg_write_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           en;
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   q;
   logic           busy;

   int total = 0;
   int bad   = 0;

   // Transaction-level reference: phase 0 = waiting, 1 = granted, 2 = committing.
   int           m_phase;
   int           m_sel;
   int           m_ptr;
   logic [W-1:0] m_q;

   int glog[$];
   int qlog[$];

   always #5 clk = ~clk;

   reg_write_arbiter #(
      .N_REQ (N),
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .busy  (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_winner(input logic [N-1:0] r, input int p);
      for (int k = 1; k <= N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_sel   = 0;
      m_ptr   = N - 1;
      m_q     = '0;
   endtask

   task automatic model_step();
      case (m_phase)
         0: if (en && req != 0) begin
               m_sel   = rr_winner(req, m_ptr);
               m_phase = 1;
            end
         1: if (req[m_sel]) begin
               m_q     = wdata[m_sel*W +: W];
               m_phase = 2;
            end else begin
               m_phase = 0;
            end
         default: begin
            m_ptr   = m_sel;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic compare();
      logic [N-1:0] eg;
      logic [N-1:0] ea;
      eg = (m_phase == 1) ? N'(1 << m_sel) : '0;
      ea = (m_phase == 2) ? N'(1 << m_sel) : '0;
      check("gnt", gnt, eg);
      check("ack", ack, ea);
      check("q", q, m_q);
      check("busy", busy, m_phase != 0);
      check("gnt_ack_excl", (gnt & ack) == 0 && $countones(gnt) <= 1 && $countones(ack) <= 1, 1);
      if (gnt != 0) glog.push_back(onehot_idx(gnt));
      if (ack != 0) qlog.push_back(int'(q));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic async_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      req   = '0;
      wdata = '0;
      model_reset();
      @(negedge clk);
      compare();
      check("rst_q", q, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;

      // Single requester write of A5.
      en = 1'b1; req = 4'b0001; wdata[7:0] = 8'hA5;
      cycle(); check("t031_gnt", gnt, 4'b0001);
      cycle(); check("t031_q", q, 8'hA5); check("t031_ack", ack, 4'b0001);
      req = '0;
      cycle(); check("t031_busy", busy, 0);

      // All requesting: fair rotation from requester 0 after reset.
      async_reset();
      glog.delete(); qlog.delete();
      for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'h10 + W'(i);
      req = 4'b1111;
      for (int c = 0; c < 15; c++) cycle();
      req = '0;
      cycle(); cycle();
      check("t032_ngrants", glog.size() >= 5 && qlog.size() >= 5, 1);
      if (glog.size() >= 5 && qlog.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            check("t032_order", glog[i], i % N);
            check("t032_q", qlog[i], 32'h10 + (i % N));
         end
      end

      // Withdrawal during GRANT: no write, pointer kept (last winner 0).
      req = 4'b0100; wdata[2*W +: W] = 8'hEE;
      cycle(); check("t033_gnt", gnt, 4'b0100);
      req = '0;
      cycle(); check("t033_q", q, 8'h10); check("t033_ack", ack, 0);
      req = 4'b1111;
      cycle(); check("t033_next", gnt, 4'b0010);
      cycle(); cycle();
      req = '0;
      cycle();

      // Reset in the middle of GRANT with q = 3C.
      req = 4'b0001; wdata[7:0] = 8'h3C;
      cycle(); cycle();
      req = '0;
      cycle(); check("t034_q_pre", q, 8'h3C);
      req = 4'b0010;
      cycle(); check("t034_gnt_pre", gnt, 4'b0010);
      req = '0;
      reset = 1'b1;
      #1;
      check("t034_q", q, 0); check("t034_gnt", gnt, 0); check("t034_busy", busy, 0);
      model_reset();
      cycle();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle(); check("t034_noack", ack, 0);
      end

      // Enable gating.
      en = 1'b0; req = 4'b0010;
      cycle(); cycle();
      check("t035_gnt_off", gnt, 0); check("t035_busy_off", busy, 0);
      en = 1'b1;
      cycle(); check("t035_gnt_on", gnt, 4'b0010);
      cycle(); req = '0; cycle();

      // Wrap-around after requester 3 wins.
      req = 4'b1000;
      cycle(); cycle(); req = '0; cycle();
      req = 4'b1001;
      cycle(); check("t036_wrap", gnt, 4'b0001);
      cycle(); req = '0; cycle();

      // Randomized traffic, with occasional enable drops and resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            wdata = {$urandom};
            cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
